uart_tx: RTL and testbench

- Serial UART transmitter; the transmit-side counterpart of the UART_RX datapath.
- Runs on the same oversampling clock as the receiver and uses the same Prescale value (8, 16 or 32 clocks per bit), so one clock domain serves both directions.
- Accepts a parallel byte with a single-cycle valid strobe.
- Serialises it LSB-first as: start bit, data bits, optional parity bit, one stop bit.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 46 ++++
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default widths and line idle level.
// Used by both the transmitter and the receiver FSMs.
package uart_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int PRESC_WIDTH_DEF = 6;

  // Level driven on the serial line when no frame is in flight.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_bit_timer.sv
// Bit timer for the UART transmitter: an edge counter that wraps every
// Prescale clocks (0 treated as 1) and a bit counter advanced on each wrap.
module uart_tx_bit_timer #(
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   i_en,
  input  logic                   i_bit_en,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic                   o_bit_done,
  output logic [3:0]             o_bit_cnt
);

  logic [PRESC_WIDTH-1:0] r_edge_cnt;
  logic [PRESC_WIDTH-1:0] w_last_edge;
  logic [3:0]             r_bit_cnt;

  // A prescale of 0 behaves like 1, so the last edge index is 0 in both cases.
  assign w_last_edge = (i_presc == '0) ? '0 : (i_presc - PRESC_WIDTH'(1));
  assign o_bit_done  = i_en && (r_edge_cnt == w_last_edge);
  assign o_bit_cnt   = r_bit_cnt;

  // Edge counter: runs while enabled, restarts at 0 after each bit period.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
    end else if (!i_en || o_bit_done) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_WIDTH'(1);
    end
  end

  // Bit counter: held at 0 outside the data phase, counts completed data bits.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_bit_cnt <= '0;
    end else if (!i_bit_en) begin
      r_bit_cnt <= '0;
    end else if (o_bit_done) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

endmodule : uart_tx_bit_timer

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a one-cycle strobe and sends it LSB-first
// as start bit, data bits, optional parity bit and one stop bit. TX_OUT and
// Busy are registered and take the value of the state being entered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  uart_state_e            r_state;
  uart_state_e            w_state_nxt;
  logic                   r_tx;
  logic                   w_tx_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   w_accept;
  logic                   w_shift;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [DATA_WIDTH-1:0]  w_shreg_sh;
  logic                   r_par_bit;
  logic                   r_par_en;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic                   w_bit_done;
  logic [3:0]             w_bit_cnt;

  // Parity bit for the frame: even parity yields XOR of data, odd inverts it.
  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d,
                                        input logic                  odd);
    return (^d) ^ odd;
  endfunction

  assign w_shreg_sh = r_shreg >> 1;
  assign TX_OUT     = r_tx;
  assign Busy       = r_busy;

  uart_tx_bit_timer #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_bit_timer (
    .clk        (clk),
    .RST        (RST),
    .i_en       (r_state != IDLE),
    .i_bit_en   (r_state == DATA),
    .i_presc    (r_presc),
    .o_bit_done (w_bit_done),
    .o_bit_cnt  (w_bit_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the line/busy values belonging to that next state.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_busy_nxt = 1'b0;
        if (Data_Valid) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shreg[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (w_bit_cnt == LAST_BIT) begin
            if (r_par_en) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = LINE_IDLE;
            end
          end else begin
            w_shift  = 1'b1;
            w_tx_nxt = w_shreg_sh[0];
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_tx_nxt    = LINE_IDLE;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = LINE_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = LINE_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered serial line and busy flag.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_tx   <= LINE_IDLE;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Frame settings latched on accept; the shift register drops one bit per data bit.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_shreg   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_presc   <= '0;
    end else if (w_accept) begin
      r_shreg   <= P_DATA;
      r_par_bit <= frame_parity(P_DATA, PAR_TYP);
      r_par_en  <= PAR_EN;
      r_presc   <= Prescale;
    end else if (w_shift) begin
      r_shreg   <= w_shreg_sh;
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model expands every accepted
// request into per-clock expected line/busy values; a compare process checks
// them every cycle, and directed frames pin the model with literal waveforms.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       dv = 1'b0;
  logic       pe = 1'b0;
  logic       pt = 1'b0;
  logic [5:0] ps = 6'd0;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .clk        (clk),
    .RST        (rst_n),
    .P_DATA     (pd),
    .Data_Valid (dv),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .Prescale   (ps),
    .TX_OUT     (tx),
    .Busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] exp_q[$];
  logic       cur_tx = 1'b1;
  logic       cur_busy = 1'b0;
  logic       cur_in = 1'b0;

  task automatic build_frame(input logic [7:0] d, input logic en, input logic typ,
                             input logic [5:0] p);
    int   len;
    logic bits[$];
    len = (p == 6'd0) ? 1 : int'(p);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (en) bits.push_back((^d) ^ typ);
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < len; c++) exp_q.push_back({bits[k], 1'b1});
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        cur_tx   = 1'b1;
        cur_busy = 1'b0;
        cur_in   = 1'b0;
      end else begin
        if (!cur_in && dv) build_frame(pd, pe, pt, ps);
        if (exp_q.size() > 0) begin
          {cur_tx, cur_busy} = exp_q.pop_front();
          cur_in = 1'b1;
        end else begin
          cur_tx   = 1'b1;
          cur_busy = 1'b0;
          cur_in   = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_tx", 32'(tx), 32'(cur_tx));
      check("cyc_busy", 32'(busy), 32'(cur_busy));
    end
  end

  // ---------------- directed frame with literal expectations ----------------
  // line[k] is the expected level of bit k (k=0 is the start bit).
  task automatic lit_frame(input logic [7:0] a_d, input logic a_pe, input logic a_pt,
                           input logic [5:0] a_ps, input int bit_len, input int nb,
                           input int len, input logic [10:0] line, input int mid);
    int busy_cnt;
    @(posedge clk);
    #1;
    pd = a_d; pe = a_pe; pt = a_pt; ps = a_ps; dv = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < len + 4; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if ((c % bit_len) == (bit_len / 2) && (c / bit_len) < nb)
        check("lit_bit", 32'(tx), 32'(line[c / bit_len]));
      if (c == mid) begin
        pd = 8'hFF;
        ps = 6'd8;
      end
    end
    check("lit_busy_len", 32'(busy_cnt), 32'(len));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gaps;
    int gap_len;
    logic prev_busy;
    logic in_gap;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, 8 clocks/bit, no parity: 0,1,0,1,0,0,1,0,1,1
    lit_frame(8'hA5, 1'b0, 1'b0, 6'd8, 8, 10, 80, 11'b01101001010, -1);
    // 0x03, 16 clocks/bit, even parity -> parity 0
    lit_frame(8'h03, 1'b1, 1'b0, 6'd16, 16, 11, 176, 11'b10000000110, -1);
    // 0x03, odd parity -> parity 1
    lit_frame(8'h03, 1'b1, 1'b1, 6'd16, 16, 11, 176, 11'b11000000110, -1);
    // 0x00, 32 clocks/bit, odd parity, inputs disturbed mid-frame
    lit_frame(8'h00, 1'b1, 1'b1, 6'd32, 32, 11, 352, 11'b11000000000, 50);
    // Prescale 0 behaves as 1: 0,1,0,0,0,0,0,0,1,1
    lit_frame(8'h81, 1'b0, 1'b0, 6'd0, 1, 10, 10, 11'b01100000010, -1);

    // Asynchronous reset in the middle of the data bits.
    @(posedge clk);
    #1;
    pd = 8'h3C; pe = 1'b0; ps = 6'd8; dv = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lit_frame(8'hA5, 1'b0, 1'b0, 6'd8, 8, 10, 80, 11'b01101001010, -1);

    // Data_Valid held high: exactly one idle clock between frames.
    @(posedge clk);
    #1;
    pd = 8'h55; pe = 1'b0; ps = 6'd8; dv = 1'b1;
    gaps = 0;
    gap_len = 0;
    in_gap = 1'b0;
    prev_busy = 1'b0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        in_gap = 1'b1;
        gap_len = 0;
      end
      if (in_gap && !busy) gap_len++;
      if (in_gap && busy) begin
        check("b2b_gap", 32'(gap_len), 32'd1);
        gaps++;
        in_gap = 1'b0;
      end
      prev_busy = busy;
    end
    check("b2b_frames", 32'(gaps >= 2), 32'd1);
    @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (100) @(posedge clk);

    // Randomized traffic: sparse strobes, inputs changing at random times.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      dv = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        pd = 8'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
        case ($urandom_range(0, 3))
          0: ps = 6'd8;
          1: ps = 6'd16;
          2: ps = 6'd32;
          default: ps = 6'($urandom_range(0, 12));
        endcase
      end
    end
    dv = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx
